sprite_blitter: RTL and testbench

- Copies one digit/score sprite from a sprite ROM into the 8-bit frame-buffer RAM at a requested on-screen position.
- The sprite ROM has 1-cycle registered read latency: address in, byte out.
- This block is the ROM's read-side master and the frame buffer's write-side master.
- It is started by the score/pin-screen controller and reports completion with a done pulse.

---
 rtl/sprite_blitter_pkg.sv | 41 ++++
 rtl/blit_raster_counter.sv | 57 +++++
 rtl/sprite_blitter.sv | 171 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_blitter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sprite_blitter_pkg
// Brief   : Shared geometry constants, state encoding and address helper
//           for the sprite blitter.
// Revision: 1.0 - initial release
// ============================================================================
package sprite_blitter_pkg;

  localparam int SPR_W  = 96;
  localparam int SPR_H  = 71;
  localparam int SPR_N  = SPR_W * SPR_H;
  localparam int ROM_AW = 13;
  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int FB_AW  = 17;

  // Counter and screen-coordinate widths
  localparam int COL_W  = 7;   // 0..95
  localparam int ROW_W  = 7;   // 0..70
  localparam int X_W    = 10;  // dest_x (max 511) + col (max 95)
  localparam int Y_W    = 9;   // dest_y (max 255) + row (max 70)

  localparam logic [7:0] KEY = 8'hE3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Frame-buffer address of the sprite origin: y*320 + x built from shifts,
  // since 320 = 256 + 64.
  function automatic logic [FB_AW-1:0] fb_base(input logic [8:0] x,
                                               input logic [7:0] y);
    return FB_AW'({y, 8'h00}) + FB_AW'({y, 6'h00}) + FB_AW'(x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/blit_raster_counter.sv
`default_nettype none
// ============================================================================
// Module  : blit_raster_counter
// Brief   : Raster walker over the sprite: column/row counters, linear ROM
//           address and the frame-buffer offset of the current pixel
//           relative to the sprite origin.
// Revision: 1.0 - initial release
// ============================================================================
module blit_raster_counter
  import sprite_blitter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic [FB_AW-1:0]  fb_off_o,
  output logic              last_o
);

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SPR_W - 1);
  localparam logic [ROM_AW-1:0] PIX_LAST = ROM_AW'(SPR_N - 1);

  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic [FB_AW-1:0]  row_base_q;

  // Advance one pixel per step; row base accumulates FB_W per sprite row
  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      col_q      <= '0;
      row_q      <= '0;
      rom_addr_q <= '0;
      row_base_q <= '0;
    end else if (step_i) begin
      rom_addr_q <= rom_addr_q + 1'b1;
      if (col_q == COL_LAST) begin
        col_q      <= '0;
        row_q      <= row_q + 1'b1;
        row_base_q <= row_base_q + FB_AW'(FB_W);
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign rom_addr_o = rom_addr_q;
  assign fb_off_o   = row_base_q + FB_AW'(col_q);
  assign last_o     = (rom_addr_q == PIX_LAST);

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module  : sprite_blitter
// Brief   : Copies one sprite from a 1-cycle-latency ROM into the 8-bit
//           frame buffer at (dest_x, dest_y) with clipping and optional
//           colour-key transparency. One pixel per cycle, no stalls.
// Revision: 1.0 - initial release
// ============================================================================
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter bit KEY_EN = 1'b1
) (
  input  logic              clk_pix_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [8:0]        dest_x_i,
  input  logic [7:0]        dest_y_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  output logic              fb_we_o,
  output logic [FB_AW-1:0]  fb_addr_o,
  output logic [7:0]        fb_wdata_o
);

  localparam logic [X_W-1:0] X_LIM = X_W'(FB_W);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(FB_H);

  state_e            state_q, state_d;
  logic              drain_q, drain_d;
  logic              load, step;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [FB_AW-1:0]  fb_off;
  logic              last;

  logic [8:0]        dest_x_q;
  logic [7:0]        dest_y_q;
  logic [FB_AW-1:0]  base_q;

  logic              s1_valid_q;
  logic [X_W-1:0]    s1_x_q;
  logic [Y_W-1:0]    s1_y_q;
  logic [FB_AW-1:0]  s1_addr_q;

  logic              key_ok;
  logic              pix_ok;

  logic              fb_we_q;
  logic [FB_AW-1:0]  fb_addr_q;
  logic [7:0]        fb_wdata_q;

  blit_raster_counter u_cnt (
    .clk_i      (clk_pix_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .step_i     (step),
    .col_o      (col),
    .row_o      (row),
    .rom_addr_o (rom_addr_o),
    .fb_off_o   (fb_off),
    .last_o     (last)
  );

  // FSM state register plus the one-bit drain cycle counter
  always_ff @(posedge clk_pix_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so it is never queued
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          step = 1'b1;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = DONE;
          drain_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the destination once per blit; later input changes are ignored
  always_ff @(posedge clk_pix_i) begin
    if (rst_i) begin
      dest_x_q <= '0;
      dest_y_q <= '0;
      base_q   <= '0;
    end else if (load) begin
      dest_x_q <= dest_x_i;
      dest_y_q <= dest_y_i;
      base_q   <= fb_base(dest_x_i, dest_y_i);
    end
  end

  // Stage 1 travels alongside the outstanding ROM read
  always_ff @(posedge clk_pix_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= (state_q == RUN);
      s1_x_q     <= X_W'(dest_x_q) + X_W'(col);
      s1_y_q     <= Y_W'(dest_y_q) + Y_W'(row);
      s1_addr_q  <= base_q + fb_off;
    end
  end

  generate
    if (KEY_EN) begin : g_key_on
      assign key_ok = (rom_data_i != KEY);
    end else begin : g_key_off
      assign key_ok = 1'b1;
    end
  endgenerate

  // Off-screen pixels are dropped here, so fb_addr never needs to wrap
  assign pix_ok = s1_valid_q && (s1_x_q < X_LIM) && (s1_y_q < Y_LIM) && key_ok;

  // Registered write port; addr/data are don't-care when the strobe is low
  always_ff @(posedge clk_pix_i) begin
    if (rst_i) begin
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      fb_we_q    <= pix_ok;
      fb_addr_q  <= s1_addr_q;
      fb_wdata_q <= rom_data_i;
    end
  end

  assign busy_o     = (state_q == RUN) || (state_q == DRAIN);
  assign done_o     = (state_q == DONE);
  assign fb_we_o    = fb_we_q;
  assign fb_addr_o  = fb_addr_q;
  assign fb_wdata_o = fb_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprite_blitter
// Brief   : Self-checking bench. Two blitters (keying off / on) share one
//           stimulus; a cycle-level model derived from the blit timing rules
//           predicts every output, and literal expectations pin key numbers.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;
  import sprite_blitter_pkg::*;

  localparam int N = SPR_W * SPR_H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [8:0]        dest_x = '0;
  logic [7:0]        dest_y = '0;
  logic [1:0]        busy, done, fb_we;
  logic [ROM_AW-1:0] rom_addr [2];
  logic [7:0]        rom_data [2];
  logic [FB_AW-1:0]  fb_addr  [2];
  logic [7:0]        fb_wdata [2];

  sprite_blitter #(.KEY_EN(1'b0)) u_dut_op (
    .clk_pix_i(clk), .rst_i(rst), .start_i(start),
    .dest_x_i(dest_x), .dest_y_i(dest_y),
    .busy_o(busy[0]), .done_o(done[0]),
    .rom_addr_o(rom_addr[0]), .rom_data_i(rom_data[0]),
    .fb_we_o(fb_we[0]), .fb_addr_o(fb_addr[0]), .fb_wdata_o(fb_wdata[0]));

  sprite_blitter #(.KEY_EN(1'b1)) u_dut_key (
    .clk_pix_i(clk), .rst_i(rst), .start_i(start),
    .dest_x_i(dest_x), .dest_y_i(dest_y),
    .busy_o(busy[1]), .done_o(done[1]),
    .rom_addr_o(rom_addr[1]), .rom_data_i(rom_data[1]),
    .fb_we_o(fb_we[1]), .fb_addr_o(fb_addr[1]), .fb_wdata_o(fb_wdata[1]));

  // Sprite ROM contents: 0 = low address byte, 1 = key/1F alternating,
  // 2 = scrambled bytes that occasionally hit the key colour
  int rom_mode = 0;
  function automatic logic [7:0] rom_fn(input int mode, input int a);
    logic [31:0] av;
    av = a;
    case (mode)
      0:       return av[7:0];
      1:       return av[0] ? 8'h1F : 8'hE3;
      default: return av[7:0] ^ 8'h5A;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    rom_data[0] <= rom_fn(rom_mode, int'(rom_addr[0]));
    rom_data[1] <= rom_fn(rom_mode, int'(rom_addr[1]));
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Model state: cycle after edge e is numbered e+1
  int ec = 0;
  bit m_active = 1'b0;
  int m_k = 0, m_dx = 0, m_dy = 0, m_rom = 0;

  // Observed statistics
  int wr_cnt [2];
  int non1f  [2];
  int done_cnt [2];
  int done_c [2];
  int first_addr [2];
  int last_addr [2];

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      wr_cnt[d] = 0; non1f[d] = 0; done_cnt[d] = 0; done_c[d] = 0;
      first_addr[d] = 0; last_addr[d] = 0;
    end
  endtask

  // Model update on each edge, full comparison half a cycle later
  initial begin
    int cyc, pi, col, row, px, py, e_addr;
    bit e_busy, e_done;
    bit e_we [2];
    logic [7:0] e_data;
    clear_stats();
    forever begin
      @(posedge clk);
      ec++;
      if (rst === 1'b1) begin
        m_active = 1'b0;
        m_rom    = 0;
      end else if (start === 1'b1 && (!m_active || ec >= m_k + N + 4)) begin
        m_active = 1'b1;
        m_k      = ec;
        m_dx     = int'(dest_x);
        m_dy     = int'(dest_y);
      end
      cyc    = ec + 1;
      e_busy = m_active && cyc >= m_k + 1 && cyc <= m_k + N + 2;
      e_done = m_active && cyc == m_k + N + 3;
      if (m_active && cyc >= m_k + 1 && cyc <= m_k + N) m_rom = cyc - m_k - 1;
      pi = cyc - m_k - 3;
      e_we[0] = 1'b0; e_we[1] = 1'b0; e_addr = 0; e_data = '0;
      if (m_active && pi >= 0 && pi < N) begin
        col = pi % SPR_W; row = pi / SPR_W;
        px = m_dx + col;  py = m_dy + row;
        e_data = rom_fn(rom_mode, pi);
        e_addr = py * FB_W + px;
        if (px < FB_W && py < FB_H) begin
          e_we[0] = 1'b1;
          e_we[1] = (e_data != KEY);
        end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(e_busy));
        chk($sformatf("done[%0d]", d), 32'(done[d]), 32'(e_done));
        chk($sformatf("rom_addr[%0d]", d), 32'(rom_addr[d]), m_rom);
        chk($sformatf("fb_we[%0d]", d), 32'(fb_we[d]), 32'(e_we[d]));
        if (e_we[d]) begin
          chk($sformatf("fb_addr[%0d]", d), 32'(fb_addr[d]), e_addr);
          chk($sformatf("fb_wdata[%0d]", d), 32'(fb_wdata[d]), 32'(e_data));
        end
        if (fb_we[d] === 1'b1) begin
          if (wr_cnt[d] == 0) first_addr[d] = int'(fb_addr[d]);
          last_addr[d] = int'(fb_addr[d]);
          wr_cnt[d]++;
          if (fb_wdata[d] !== 8'h1F) non1f[d]++;
        end
        if (done[d] === 1'b1) begin
          done_cnt[d]++;
          done_c[d] = cyc;
        end
      end
    end
  end

  // Drive a one-edge start pulse, then scramble dest to show it is ignored
  task automatic pulse_start(input int x, input int y);
    dest_x = 9'(x);
    dest_y = 8'(y);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dest_x = 9'($urandom);
    dest_y = 8'($urandom);
  endtask

  // Wait (bounded) until done is seen at a negedge, optionally glitching start
  task automatic wait_done(input string nm, input bit glitch);
    int t;
    t = 0;
    while (done[0] !== 1'b1 && t < 8000) begin
      @(negedge clk);
      if (glitch) start = ($urandom_range(0, 63) == 0);
      t++;
    end
    start = 1'b0;
    if (t >= 8000) chk({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  function automatic int vis(input int pos, input int span, input int lim);
    int v;
    v = lim - pos;
    if (v < 0) v = 0;
    if (v > span) v = span;
    return v;
  endfunction

  initial begin
    int k, d1, wc, w0, rx, ry;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_rom_addr", 32'(rom_addr[0]), 32'd0);
    chk("reset_fb_we", 32'(fb_we), 32'd0);

    // Opaque blit at the origin
    clear_stats(); rom_mode = 0;
    pulse_start(0, 0); k = m_k;
    wait_done("opaque", 1'b0);
    repeat (2) @(negedge clk);
    chk("opaque_writes", wr_cnt[0], 6816);
    chk("opaque_done_lat", done_c[0] - k, 6819);
    chk("opaque_last_addr", last_addr[0], 70 * 320 + 95);

    // Transparency: even addresses are key colour
    clear_stats(); rom_mode = 1;
    pulse_start(0, 0);
    wait_done("key", 1'b0);
    repeat (2) @(negedge clk);
    chk("key_writes", wr_cnt[1], 3408);
    chk("key_non1f", non1f[1], 0);
    chk("key_off_writes", wr_cnt[0], 6816);

    // Clipping at the bottom-right corner
    clear_stats(); rom_mode = 0;
    pulse_start(300, 200);
    wait_done("clip", 1'b0);
    repeat (2) @(negedge clk);
    chk("clip_writes", wr_cnt[0], 800);
    chk("clip_first", first_addr[0], 64300);
    chk("clip_last", last_addr[0], 76799);

    // Start pulses while busy and during DONE are ignored
    clear_stats(); rom_mode = 2;
    pulse_start(5, 7); k = m_k;
    while (ec < k + 99) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done("ign", 1'b0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("ign_done_cnt", done_cnt[0], 1);
    chk("ign_writes", wr_cnt[0], 6816);
    chk("ign_busy_after", 32'(busy[0]), 32'd0);

    // Reset in the middle of a blit
    clear_stats(); rom_mode = 0;
    pulse_start(20, 30); k = m_k;
    while (ec < k + 499) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_we", 32'(fb_we[0]), 32'd0);
    w0 = wr_cnt[0];
    repeat (20) @(negedge clk);
    chk("rst_no_writes", wr_cnt[0] - w0, 0);
    chk("rst_no_done", done_cnt[0], 0);
    clear_stats();
    pulse_start(10, 10);
    wait_done("rst_reblit", 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_reblit_writes", wr_cnt[0], 6816);
    chk("rst_reblit_done", done_cnt[0], 1);

    // Back-to-back with start held high
    clear_stats(); rom_mode = 0;
    dest_x = 9'd40; dest_y = 8'd50; start = 1'b1;
    wait_done("b2b_1", 1'b0);
    start = 1'b1;
    d1 = ec + 1; wc = 0;
    for (int t = 0; t < 20 && wc == 0; t++) begin
      @(negedge clk);
      if (fb_we[0] === 1'b1) wc = ec + 1;
    end
    start = 1'b0;
    chk("b2b_first_write", wc - d1, 4);
    wait_done("b2b_2", 1'b0);
    repeat (3) @(negedge clk);
    chk("b2b_done_cnt", done_cnt[0], 2);
    chk("b2b_writes", wr_cnt[0], 2 * 6816);

    // Randomized positions and contents with stray start pulses
    for (int r = 0; r < 2; r++) begin
      clear_stats();
      rom_mode = int'($urandom_range(0, 2));
      rx = int'($urandom_range(0, 511));
      ry = int'($urandom_range(0, 255));
      pulse_start(rx, ry);
      wait_done("rand", 1'b1);
      repeat (3) @(negedge clk);
      chk("rand_writes", wr_cnt[0], vis(rx, SPR_W, FB_W) * vis(ry, SPR_H, FB_H));
      chk("rand_done_cnt", done_cnt[0], 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
